// File: rtl/iu_hazard_if.sv
// ID-stage <-> hazard unit signal bundle: issue request, operand reads,
// stall/forward response and writeback port.
interface iu_hazard_if #(
  parameter int RW = 5,
  parameter int LW = 2
);
  logic          hold;
  logic          id_valid;
  logic          id_wreg;
  logic [RW-1:0] id_rn;
  logic [LW-1:0] id_lat;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          stall;
  logic [LW-1:0] fwda;
  logic [LW-1:0] fwdb;
  logic          w_valid;
  logic [RW-1:0] w_rn;

  modport master (
    output hold, id_valid, id_wreg, id_rn, id_lat, id_rs, id_rt, id_use_rs, id_use_rt,
    input  stall, fwda, fwdb, w_valid, w_rn
  );

  modport slave (
    input  hold, id_valid, id_wreg, id_rn, id_lat, id_rs, id_rt, id_use_rs, id_use_rt,
    output stall, fwda, fwdb, w_valid, w_rn
  );
endinterface

// File: rtl/iu_hazard_unit.sv
// Hazard-detection / forwarding scoreboard over DEPTH post-ID stages.
// Define IU_HAZ_STATS_EN to add saturating stall/forward/hold counters.
module iu_hazard_unit #(
  parameter int NREG  = 32,
  parameter int RW    = 5,
  parameter int DEPTH = 3,
  parameter int LW    = 2
) (
  input  logic        clk,
  input  logic        clrn,
  iu_hazard_if.slave  bus
`ifdef IU_HAZ_STATS_EN
  ,
  output logic [31:0] stat_stall,
  output logic [31:0] stat_fwd,
  output logic [31:0] stat_hold
`endif
);

  typedef struct packed {
    logic          v;
    logic [RW-1:0] rn;
    logic [LW-1:0] lat;
  } entry_t;

  typedef entry_t [DEPTH:1] bank_t;

  typedef struct packed {
    logic          req;
    logic [LW-1:0] fwd;
  } look_t;

  bank_t  ent;
  entry_t new_e;
  look_t  look_a;
  look_t  look_b;
  logic   issue;

  // Scan oldest to youngest so the youngest matching producer overwrites.
  function automatic look_t lookup(input logic used, input logic [RW-1:0] r,
                                   input bank_t e);
    look_t res;
    res = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (used && r != '0 && e[k].v && e[k].rn == r) begin
        res.req = (k < int'(e[k].lat));
        res.fwd = res.req ? '0 : LW'(k);
      end
    end
    return res;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    new_e     = '0;
    new_e.v   = bus.id_wreg && bus.id_rn != '0 && int'(bus.id_rn) < NREG;
    new_e.rn  = bus.id_rn;
    if (bus.id_lat == '0)
      new_e.lat = LW'(1);
    else if (int'(bus.id_lat) > DEPTH)
      new_e.lat = LW'(DEPTH);
    else
      new_e.lat = bus.id_lat;
  end

  always_comb begin
    look_a = lookup(bus.id_use_rs, bus.id_rs, ent);
    look_b = lookup(bus.id_use_rt, bus.id_rt, ent);
  end

  assign bus.stall   = bus.id_valid & (look_a.req | look_b.req);
  assign bus.fwda    = look_a.fwd;
  assign bus.fwdb    = look_b.fwd;
  assign issue       = bus.id_valid & ~bus.stall & ~bus.hold;
  assign bus.w_valid = ent[DEPTH].v;
  assign bus.w_rn    = ent[DEPTH].rn;

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so the shift reads pre-edge values.
    if (clrn) begin
      // NOTE: the whole bank is cleared, not just v, so w_rn reads 0 after reset.
      ent <= '0;
    end else if (!bus.hold) begin
      for (int k = DEPTH; k >= 2; k--)
        ent[k] <= ent[k-1];
      ent[1] <= issue ? new_e : '0;
    end
  end

`ifdef IU_HAZ_STATS_EN
  logic fwd_issue;
  assign fwd_issue = issue & ((bus.fwda != '0) | (bus.fwdb != '0));

  always_ff @(posedge clk) begin
    if (clrn) begin
      stat_stall <= '0;
      stat_fwd   <= '0;
      stat_hold  <= '0;
    end else begin
      if (bus.stall && !bus.hold && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
      if (fwd_issue && stat_fwd != '1)                stat_fwd   <= stat_fwd + 32'd1;
      if (bus.hold && stat_hold != '1)                stat_hold  <= stat_hold + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iu_hazard_unit.sv
// Self-checking bench for iu_hazard_unit: directed scenarios plus random traffic
// compared against a timestamp-based model of in-flight register writes.
module tb_iu_hazard_unit;
  localparam int NREG  = 32;
  localparam int RW    = 5;
  localparam int DEPTH = 3;
  localparam int LW    = 2;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  iu_hazard_if #(.RW(RW), .LW(LW)) bus ();

`ifdef IU_HAZ_STATS_EN
  logic [31:0] stat_stall, stat_fwd, stat_hold;
`endif

  iu_hazard_unit #(.NREG(NREG), .RW(RW), .DEPTH(DEPTH), .LW(LW)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
`ifdef IU_HAZ_STATS_EN
    ,
    .stat_stall (stat_stall),
    .stat_fwd   (stat_fwd),
    .stat_hold  (stat_hold)
`endif
  );

  // Model: each issued write remembers the advance count at which it issued;
  // its current stage is (adv - t).
  typedef struct {
    int rn;
    int lat;
    int t;
  } wr_t;

  wr_t wq[$];
  int  adv;
  int  m_stall_cnt, m_fwd_cnt, m_hold_cnt;

  int  n_cmp = 0;
  int  n_err = 0;

  bit  exp_issue, exp_stall, req_a, req_b;
  int  exp_fwda, exp_fwdb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void look(input bit used, input int r, output bit req, output int fwd);
    int best, blat, age;
    best = 0;
    blat = 0;
    foreach (wq[i]) begin
      age = adv - wq[i].t;
      if (used && r != 0 && wq[i].rn == r && age >= 1 && age <= DEPTH &&
          (best == 0 || age < best)) begin
        best = age;
        blat = wq[i].lat;
      end
    end
    req = (best != 0) && (best < blat);
    fwd = req ? 0 : best;
  endfunction

  function automatic void model_reset();
    wq.delete();
    adv = 0;
    m_stall_cnt = 0;
    m_fwd_cnt   = 0;
    m_hold_cnt  = 0;
  endfunction

  task automatic reset_dut(input int cycles, input bit hold);
    @(negedge clk);
    clrn         = 1'b1;
    bus.hold     = hold;
    bus.id_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    model_reset();
  endtask

  // Drive one ID cycle, then compare outputs against the model before the edge.
  task automatic apply(input bit v, input bit wreg, input int rn, input int lat,
                       input int rs, input bit urs, input int rt, input bit urt,
                       input bit hold);
    int  wv, wrn, age;
    @(negedge clk);
    clrn          = 1'b0;
    bus.hold      = hold;
    bus.id_valid  = v;
    bus.id_wreg   = wreg;
    bus.id_rn     = RW'(rn);
    bus.id_lat    = LW'(lat);
    bus.id_rs     = RW'(rs);
    bus.id_use_rs = urs;
    bus.id_rt     = RW'(rt);
    bus.id_use_rt = urt;
    #1;
    look(urs, rs, req_a, exp_fwda);
    look(urt, rt, req_b, exp_fwdb);
    exp_stall = v && (req_a || req_b);
    exp_issue = v && !exp_stall && !hold;
    wv  = 0;
    wrn = 0;
    foreach (wq[i]) begin
      age = adv - wq[i].t;
      if (age == DEPTH) begin
        wv  = 1;
        wrn = wq[i].rn;
      end
    end
    check("stall", 32'(bus.stall), 32'(exp_stall));
    if (!req_a) check("fwda", 32'(bus.fwda), 32'(exp_fwda));
    if (!req_b) check("fwdb", 32'(bus.fwdb), 32'(exp_fwdb));
    check("w_valid", 32'(bus.w_valid), 32'(wv));
    if (wv != 0) check("w_rn", 32'(bus.w_rn), 32'(wrn));
`ifdef IU_HAZ_STATS_EN
    check("stat_stall", stat_stall, 32'(m_stall_cnt));
    check("stat_fwd", stat_fwd, 32'(m_fwd_cnt));
    check("stat_hold", stat_hold, 32'(m_hold_cnt));
`endif
  endtask

  // Clock edge: advance the model using the inputs of the last apply().
  task automatic tick();
    wr_t w;
    int  nl;
    @(posedge clk);
    if (bus.hold) begin
      m_hold_cnt++;
    end else begin
      if (exp_stall) m_stall_cnt++;
      if (exp_issue && (exp_fwda != 0 || exp_fwdb != 0)) m_fwd_cnt++;
      if (exp_issue && bus.id_wreg && bus.id_rn != '0) begin
        nl = int'(bus.id_lat);
        if (nl == 0) nl = 1;
        if (nl > DEPTH) nl = DEPTH;
        w.rn  = int'(bus.id_rn);
        w.lat = nl;
        w.t   = adv;
        wq.push_back(w);
      end
      adv++;
      while (wq.size() > 0 && adv - wq[0].t > DEPTH) void'(wq.pop_front());
    end
  endtask

  initial begin
    clrn = 1'b1;
    bus.hold = 1'b0; bus.id_valid = 1'b0; bus.id_wreg = 1'b0;
    bus.id_rn = '0; bus.id_lat = '0; bus.id_rs = '0; bus.id_rt = '0;
    bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;

    // Reset state
    reset_dut(2, 1'b0);
    apply(1, 0, 0, 0, 5, 1, 0, 0, 0);
    check("rst_stall", 32'(bus.stall), 0);
    check("rst_fwda", 32'(bus.fwda), 0);
    check("rst_wv", 32'(bus.w_valid), 0);
    check("rst_wrn", 32'(bus.w_rn), 0);
    tick();

    // ALU chain: reader kept in ID with id_valid=0 sees the producer age
    apply(1, 1, 5, 1, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 5, 1, 0, 0, 0);
    check("alu_fwd1", 32'(bus.fwda), 1); tick();
    apply(0, 0, 0, 0, 5, 1, 0, 0, 0);
    check("alu_fwd2", 32'(bus.fwda), 2); tick();
    apply(1, 0, 0, 0, 5, 1, 0, 0, 0);
    check("alu_fwd3", 32'(bus.fwda), 3);
    check("alu_wv", 32'(bus.w_valid), 1);
    check("alu_wrn", 32'(bus.w_rn), 5); tick();

    // Load-use: one bubble, then forward from stage 2
    apply(1, 1, 7, 2, 0, 0, 0, 0, 0); tick();
    apply(1, 0, 0, 0, 0, 0, 7, 1, 0);
    check("ld_stall", 32'(bus.stall), 1); tick();
    apply(1, 0, 0, 0, 0, 0, 7, 1, 0);
    check("ld_go", 32'(bus.stall), 0);
    check("ld_fwdb", 32'(bus.fwdb), 2); tick();

    // Youngest producer wins; register 0 never matches
    apply(1, 1, 3, 1, 0, 0, 0, 0, 0); tick();
    apply(1, 1, 3, 1, 0, 0, 0, 0, 0); tick();
    apply(1, 0, 0, 0, 3, 1, 3, 1, 0);
    check("young_a", 32'(bus.fwda), 1);
    check("young_b", 32'(bus.fwdb), 1); tick();
    apply(1, 1, 0, 1, 0, 0, 0, 0, 0); tick();
    apply(1, 0, 0, 0, 0, 1, 0, 1, 0);
    check("r0_fwda", 32'(bus.fwda), 0);
    check("r0_stall", 32'(bus.stall), 0); tick();

    // Hold freezes the pipe while the load-use stall persists
    apply(1, 1, 9, 2, 0, 0, 0, 0, 0); tick();
    repeat (2) begin
      apply(1, 0, 0, 0, 9, 1, 0, 0, 1);
      check("hold_stall", 32'(bus.stall), 1); tick();
    end
    apply(1, 0, 0, 0, 9, 1, 0, 0, 0);
    check("hold_rel", 32'(bus.stall), 1); tick();
    apply(1, 0, 0, 0, 9, 1, 0, 0, 0);
    check("hold_fwd", 32'(bus.fwda), 2); tick();

    // Reset while a stall is pending discards everything
    apply(1, 1, 4, 3, 0, 0, 0, 0, 0); tick();
    apply(1, 0, 0, 0, 4, 1, 0, 0, 0); tick();
    reset_dut(1, 1'b1);
    apply(1, 0, 0, 0, 4, 1, 4, 1, 0);
    check("midrst_stall", 32'(bus.stall), 0);
    check("midrst_wrn", 32'(bus.w_rn), 0); tick();

    // Random traffic over a small register window to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) == 0) begin
        reset_dut(int'($urandom_range(2, 1)), 1'($urandom_range(1)));
      end
      apply(1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0),
            int'($urandom_range(7)), int'($urandom_range(3)),
            int'($urandom_range(7)), 1'($urandom_range(3) != 0),
            int'($urandom_range(7)), 1'($urandom_range(1)),
            1'($urandom_range(6) == 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
